lfsr_checker: RTL

//  Receive-side partner of the Fibonacci LFSR generator: self-synchronises a local

---
 rtl/lfsr_checker_pkg.sv | 22 ++
 rtl/lfsr_checker_sat_counter.sv | 25 ++
 rtl/lfsr_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the PRBS checker: state encodings and default polynomial.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lfsr_checker_pkg;

  // Checker states: collect seed bits, confirm predictions, then free-run
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // Default polynomial, identical to the one used by the generator
  localparam int          DEF_WIDTH    = 16;
  localparam logic [15:0] DEF_FEEDBACK = 16'h002D;

  // Bits needed to hold values 0..max_val (never less than one bit)
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count reflects inc/clr on the following clock edge.
// Backpressure: none; inc is taken every cycle it is high.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up until all-ones, then hold; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: seeds a local Fibonacci LFSR from the stream, verifies, locks, counts bit errors.
// Latency: locked/bit_error/sync_lost/err_count register the decision on the edge sampling the bit.
// Backpressure: none; every cycle with in_valid high consumes one bit, idle cycles freeze all state.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter logic [WIDTH-1:0] FEEDBACK      = DEF_FEEDBACK,
  parameter int               LOCK_COUNT    = 32,
  parameter int               LOSS_WINDOW   = 64,
  parameter int               LOSS_THRESH   = 8,
  parameter int               ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     err_clear,
  output logic                     locked,
  output logic                     bit_error,
  output logic                     sync_lost,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int FCW = cnt_bits(WIDTH);
  localparam int MCW = cnt_bits(LOCK_COUNT);
  localparam int PCW = cnt_bits(LOSS_WINDOW);
  localparam int ECW = cnt_bits(LOSS_THRESH);

  localparam logic [FCW-1:0] FILL_LAST  = FCW'(WIDTH - 1);
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(LOCK_COUNT - 1);
  localparam logic [PCW-1:0] POS_LAST   = PCW'(LOSS_WINDOW - 1);
  localparam logic [ECW-1:0] THRESH     = ECW'(LOSS_THRESH);

  chk_state_t       state, state_n;
  logic [WIDTH-1:0] lfsr_q, lfsr_n;
  logic [FCW-1:0]   fill_cnt, fill_n;
  logic [MCW-1:0]   match_cnt, match_n;
  logic [PCW-1:0]   win_pos, pos_n;
  logic [ECW-1:0]   win_err, werr_n, werr_sum;
  logic [WIDTH-1:0] shift_in;
  logic             exp_bit;
  logic             err_hit;
  logic             lost_n;

  // Next-state, LFSR update and window bookkeeping for one valid bit
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr_q;
    fill_n   = fill_cnt;
    match_n  = match_cnt;
    pos_n    = win_pos;
    werr_n   = win_err;
    werr_sum = win_err;
    err_hit  = 1'b0;
    lost_n   = 1'b0;
    exp_bit  = ^(lfsr_q & FEEDBACK);
    shift_in = {in_bit, lfsr_q[WIDTH-1:1]};

    if (in_valid) begin
      case (state)
        ST_FILL: begin
          lfsr_n = shift_in;
          if (fill_cnt == FILL_LAST) begin
            fill_n = '0;
            // An all-zero seed is the LFSR lock-up state: keep filling
            if (shift_in != '0) begin
              state_n = ST_VERIFY;
              match_n = '0;
            end
          end else begin
            fill_n = fill_cnt + 1'b1;
          end
        end

        ST_VERIFY: begin
          lfsr_n = shift_in;
          if (in_bit == exp_bit) begin
            if (match_cnt == MATCH_LAST) begin
              state_n = ST_LOCKED;
              pos_n   = '0;
              werr_n  = '0;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            state_n = ST_FILL;
            fill_n  = '0;
          end
        end

        ST_LOCKED: begin
          // Free-running: received bits never reload the local register
          lfsr_n   = {exp_bit, lfsr_q[WIDTH-1:1]};
          err_hit  = (in_bit != exp_bit);
          werr_sum = win_err + ECW'(err_hit);
          // Threshold is tested before the window wrap so a last-bit error still counts
          if (werr_sum == THRESH) begin
            state_n = ST_FILL;
            fill_n  = '0;
            lost_n  = 1'b1;
          end else if (win_pos == POS_LAST) begin
            pos_n  = '0;
            werr_n = '0;
          end else begin
            pos_n  = win_pos + 1'b1;
            werr_n = werr_sum;
          end
        end

        default: begin
          state_n = ST_FILL;
          fill_n  = '0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      lfsr_q    <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_pos   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      bit_error <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr_q    <= lfsr_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      win_pos   <= pos_n;
      win_err   <= werr_n;
      locked    <= (state_n == ST_LOCKED);
      bit_error <= err_hit;
      sync_lost <= lost_n;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_hit),
    .clr   (err_clear),
    .count (err_count)
  );

endmodule
